// File: rtl/param_divider.sv
// Sequential radix-2 restoring divider, one quotient bit per clock, WIDTH cycles per result.
// Optional two's-complement mode; divide-by-zero resolves in one cycle with q=all ones, r=a.
module param_divider #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic             signed_mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o,
  output logic             div_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ZERO} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic             done_q;
  logic             dz_q;

  logic [WIDTH:0]   r_ext;
  logic [WIDTH:0]   sub;
  logic             ge;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // The partial remainder is always below the divisor, so R' < 2*|b| and the
  // top bit of the (WIDTH+1)-bit difference is a clean borrow flag.
  always_comb begin
    r_ext   = {rem_q, dvd_q[WIDTH-1]};
    sub     = r_ext - {1'b0, dvs_q};
    ge      = ~sub[WIDTH];
    rem_d   = ge ? sub[WIDTH-1:0] : r_ext[WIDTH-1:0];
    dvd_d   = {dvd_q[WIDTH-2:0], ge};
    quo_fix = neg_quo_q ? (~dvd_d + 1'b1) : dvd_d;
    rem_fix = neg_rem_q ? (~rem_d + 1'b1) : rem_d;
    sgn     = SIGNED_EN && signed_mode_i;
    a_neg   = sgn && a_i[WIDTH-1];
    b_neg   = sgn && b_i[WIDTH-1];
    a_mag   = a_neg ? (~a_i + 1'b1) : a_i;
    b_mag   = b_neg ? (~b_i + 1'b1) : b_i;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dvs_q     <= b_mag;
            rem_q     <= '0;
            cnt_q     <= CW'(WIDTH);
            dz_q      <= 1'b0;
            // Zero divisor keeps the raw dividend so it can be returned as r.
            if (b_i == '0) begin
              dvd_q   <= a_i;
              state_q <= S_ZERO;
            end else begin
              dvd_q   <= a_mag;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            q_q     <= quo_fix;
            r_q     <= rem_fix;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_ZERO: begin
          q_q     <= '1;
          r_q     <= dvd_q;
          dz_q    <= 1'b1;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_o    = (state_q == S_IDLE);
  assign busy_o     = ~ready_o;
  assign done_o     = done_q;
  assign q_o        = q_q;
  assign r_o        = r_q;
  assign div_zero_o = dz_q;

endmodule

// File: tb/tb_param_divider.sv
// Bench for param_divider: 32-bit signed-capable and unsigned-only instances plus an 8-bit instance.
module tb_param_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        st32 = 1'b0, sm32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        rdy_s, bsy_s, dn_s, dz_s;
  logic [31:0] q_s, r_s;
  logic        rdy_u, bsy_u, dn_u, dz_u;
  logic [31:0] q_u, r_u;
  logic        st8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        rdy8, bsy8, dn8, dz8;
  logic [7:0]  q8, r8;

  param_divider #(.WIDTH(32), .SIGNED_EN(1'b1)) u_s32 (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(st32), .signed_mode_i(sm32),
    .a_i(a32), .b_i(b32), .ready_o(rdy_s), .busy_o(bsy_s), .done_o(dn_s),
    .q_o(q_s), .r_o(r_s), .div_zero_o(dz_s));

  param_divider #(.WIDTH(32), .SIGNED_EN(1'b0)) u_u32 (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(st32), .signed_mode_i(sm32),
    .a_i(a32), .b_i(b32), .ready_o(rdy_u), .busy_o(bsy_u), .done_o(dn_u),
    .q_o(q_u), .r_o(r_u), .div_zero_o(dz_u));

  param_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) u_s8 (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(st8), .signed_mode_i(sm8),
    .a_i(a8), .b_i(b8), .ready_o(rdy8), .busy_o(bsy8), .done_o(dn8),
    .q_o(q8), .r_o(r8), .div_zero_o(dz8));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Reference: plain signed/unsigned 64-bit division, truncating toward zero.
  function automatic void model(input int w, input bit sgn, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] q,
                                output logic [31:0] r, output logic dz);
    longint as, bs, mask;
    mask = (longint'(1) << w) - 1;
    as = {32'd0, a};
    bs = {32'd0, b};
    dz = (b == 32'd0);
    if (dz) begin
      q = mask[31:0];
      r = a;
    end else begin
      if (sgn && a[w-1]) as = as - (longint'(1) << w);
      if (sgn && b[w-1]) bs = bs - (longint'(1) << w);
      mask = (as / bs) & ((longint'(1) << w) - 1);
      q = mask[31:0];
      mask = (as % bs) & ((longint'(1) << w) - 1);
      r = mask[31:0];
    end
  endfunction

  task automatic run32(input logic sm, input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    st32 = 1'b1; sm32 = sm; a32 = a; b32 = b;
    @(posedge clk); #1 st32 = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (dn_s) break;
    end
  endtask

  task automatic run8(input logic sm, input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    st8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
    @(posedge clk); #1 st8 = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (dn8) break;
    end
  endtask

  typedef struct {
    logic        sm;
    logic [31:0] a, b, q1, r1, q0, r0;
    logic        dz;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int lat, npulse;
    logic [31:0] eq, er;
    logic        edz;
    logic [7:0]  t8;
    int          ri, bi;

    tbl[0] = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 32'd14, 32'd2, 1'b0};
    tbl[1] = '{1'b0, 32'hFFFFFFFF, 32'h80000001, 32'd1, 32'h7FFFFFFE, 32'd1, 32'h7FFFFFFE, 1'b0};
    tbl[2] = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'd1, 1'b0};
    tbl[3] = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 32'd0, 32'd7, 1'b0};
    tbl[4] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 32'd0, 32'h80000000, 1'b0};
    tbl[5] = '{1'b0, 32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, 32'hFFFFFFFF, 32'd1234, 1'b1};
    tbl[6] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFF9, 1'b0};
    tbl[7] = '{1'b1, 32'd20, 32'd6, 32'd3, 32'd2, 32'd3, 32'd2, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk("rst ready", 32'(rdy_s), 32'd1);
    chk("rst busy", 32'(bsy_s), 32'd0);
    chk("rst done", 32'(dn_s), 32'd0);
    chk("rst q", q_s, 32'd0);
    chk("rst r", r_s, 32'd0);
    chk("rst dz", 32'(dz_s), 32'd0);
    chk("rst8 ready", 32'(rdy8), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run32(tbl[i].sm, tbl[i].a, tbl[i].b, lat);
      chk($sformatf("v%0d latency", i), 32'(lat), tbl[i].dz ? 32'd1 : 32'd32);
      chk($sformatf("v%0d q", i), q_s, tbl[i].q1);
      chk($sformatf("v%0d r", i), r_s, tbl[i].r1);
      chk($sformatf("v%0d dz", i), 32'(dz_s), 32'(tbl[i].dz));
      chk($sformatf("v%0d uns done", i), 32'(dn_u), 32'd1);
      chk($sformatf("v%0d uns q", i), q_u, tbl[i].q0);
      chk($sformatf("v%0d uns r", i), r_u, tbl[i].r0);
    end

    // Start pulse during CALC with different operands must be ignored.
    @(negedge clk);
    st32 = 1'b1; sm32 = 1'b0; a32 = 32'd100; b32 = 32'd7;
    @(posedge clk); #1 st32 = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      if (lat == 5) begin
        st32 = 1'b1; sm32 = 1'b1; a32 = 32'd50; b32 = 32'd5;
        chk("calc busy", 32'(bsy_s), 32'd1);
        chk("calc ready", 32'(rdy_s), 32'd0);
      end else begin
        st32 = 1'b0; a32 = $urandom; b32 = $urandom;
      end
      @(posedge clk); #1;
      lat++;
      if (dn_s) break;
    end
    st32 = 1'b0;
    chk("ignore latency", 32'(lat), 32'd32);
    chk("ignore q", q_s, 32'd14);
    chk("ignore r", r_s, 32'd2);
    @(posedge clk); #1;
    chk("done one cycle", 32'(dn_s), 32'd0);
    chk("idle after done", 32'(rdy_s), 32'd1);

    // Back-to-back: start raised in the done cycle.
    run32(1'b0, 32'd200, 32'd9, lat);
    chk("b2b first done", 32'(dn_s), 32'd1);
    chk("b2b first q", q_s, 32'd22);
    st32 = 1'b1; a32 = 32'd1000; b32 = 32'd3;
    @(posedge clk); #1 st32 = 1'b0;
    chk("b2b accepted", 32'(bsy_s), 32'd1);
    chk("b2b q held", q_s, 32'd22);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (dn_s) break;
    end
    chk("b2b latency", 32'(lat), 32'd32);
    chk("b2b q", q_s, 32'd333);
    chk("b2b r", r_s, 32'd1);

    // Reset mid-CALC aborts without a done pulse.
    @(negedge clk);
    st32 = 1'b1; a32 = 32'd999; b32 = 32'd4;
    @(posedge clk); #1 st32 = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("abort ready", 32'(rdy_s), 32'd1);
    chk("abort done", 32'(dn_s), 32'd0);
    chk("abort q", q_s, 32'd0);
    chk("abort r", r_s, 32'd0);
    npulse = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (dn_s) npulse++;
    end
    chk("abort no done", 32'(npulse), 32'd0);

    run8(1'b0, 8'd200, 8'd13, lat);
    chk("w8 latency", 32'(lat), 32'd8);
    chk("w8 q", 32'(q8), 32'd15);
    chk("w8 r", 32'(r8), 32'd5);
    run8(1'b1, 8'h80, 8'd3, lat);
    chk("w8 signed q", 32'(q8), 32'hD6);
    chk("w8 signed r", 32'(r8), 32'hFE);
    run8(1'b1, 8'h85, 8'd0, lat);
    chk("w8 zero latency", 32'(lat), 32'd1);
    chk("w8 zero q", 32'(q8), 32'hFF);
    chk("w8 zero r", 32'(r8), 32'h85);
    chk("w8 zero dz", 32'(dz8), 32'd1);

    for (int i = 0; i < 1000; i++) begin
      logic       sm;
      logic [7:0] ra, rb;
      sm = 1'($urandom);
      ra = 8'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      run8(sm, ra, rb, lat);
      model(8, sm, {24'd0, ra}, {24'd0, rb}, eq, er, edz);
      chk("r8 latency", 32'(lat), edz ? 32'd1 : 32'd8);
      chk("r8 q", 32'(q8), eq);
      chk("r8 r", 32'(r8), er);
      chk("r8 dz", 32'(dz8), 32'(edz));
      if (rb != 8'd0) begin
        t8 = q8 * rb + r8;
        chk("r8 invariant", 32'(t8), 32'(ra));
        ri = sm ? int'($signed(r8)) : int'(r8);
        bi = sm ? int'($signed(rb)) : int'(rb);
        if (ri < 0) ri = -ri;
        if (bi < 0) bi = -bi;
        chk("r8 rem bound", 32'(ri < bi), 32'd1);
      end
    end

    for (int i = 0; i < 100; i++) begin
      logic        sm;
      logic [31:0] ra, rb;
      sm = 1'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 15) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      run32(sm, ra, rb, lat);
      model(32, sm, ra, rb, eq, er, edz);
      chk("r32 q", q_s, eq);
      chk("r32 r", r_s, er);
      chk("r32 dz", 32'(dz_s), 32'(edz));
      model(32, 1'b0, ra, rb, eq, er, edz);
      chk("r32 uns q", q_u, eq);
      chk("r32 uns r", r_u, er);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
